// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and bit-timing helper
//
// Contents:
//   UART_DATA_BITS   data bits per frame (8N1)
//   uart_rx_state_t  receiver FSM state encoding
//   clk_per_bit(h)   full bit period in clocks for a half-bit count h;
//                    the transmitter uses the same helper so both sides
//                    agree on the bit period
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_rx_state_t;

    function automatic int clk_per_bit(input int h);
        return 2 * h;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser for a single asynchronous input
//
// Parameters:
//   RESET_VALUE  value both flops take while reset_n is low; pick the idle
//                level of the input so reset does not create a false edge
// Ports:
//   clock    in  destination clock
//   reset_n  in  asynchronous active-low reset
//   d        in  asynchronous input
//   q        out synchronised copy of d, two clocks of latency
module uart_sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with one-entry valid/ready output register
//
// Parameters:
//   CLK_PER_HALF_BIT  clocks per half bit (H); one bit is 2H clocks; H >= 2
// Optional build macro:
//   UART_RX_MAJORITY_VOTE_EN  2-of-3 vote around every sample point; all
//                             sample decisions move one clock later
// Ports:
//   clock     in  sole clock, rising edge
//   reset_n   in  asynchronous active-low reset
//   rxd       in  asynchronous serial line, idle high
//   rdata     out received byte, valid while rx_valid
//   rx_valid  out rdata holds an unconsumed byte
//   rx_ready  in  consumer takes rdata when rx_valid & rx_ready
//   ferr      out one-cycle pulse, stop bit sampled low
//   overrun   out one-cycle pulse, byte lost because output register was full
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 30
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      rxd,
    output logic [UART_DATA_BITS-1:0] rdata,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      ferr,
    output logic                      overrun
);

    localparam int BIT_CYC = clk_per_bit(CLK_PER_HALF_BIT);
    localparam int CW      = $clog2(BIT_CYC);
    localparam int IW      = $clog2(UART_DATA_BITS);

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int VOTE_DELAY = 1;
`else
    localparam int VOTE_DELAY = 0;
`endif

    // The start decision happens at mid start bit (plus one when voting).
    // Data and stop decisions sit a whole bit after the previous decision,
    // so the vote delay carries forward without a separate offset there.
    localparam logic [CW-1:0] START_LAST = CW'(CLK_PER_HALF_BIT - 1 + VOTE_DELAY);
    localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYC - 1);
    localparam logic [IW-1:0] LAST_BIT   = IW'(UART_DATA_BITS - 1);

    logic                      rxd_s;
    logic                      sample;
    uart_rx_state_t            state;
    logic [CW-1:0]             cnt;
    logic [IW-1:0]             bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      byte_done;

    uart_sync2 #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (rxd),
        .q       (rxd_s)
    );

`ifdef UART_RX_MAJORITY_VOTE_EN
    // Free-running history of the two previous rxd_s values; at a decision
    // point it holds the samples from one and two clocks before.
    logic [1:0] hist;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], rxd_s};
        end
    end

    assign sample = (hist[1] & hist[0]) | (hist[1] & rxd_s) | (hist[0] & rxd_s);
`else
    assign sample = rxd_s;
`endif

    // A good stop bit finishes the byte; the output register logic below
    // decides whether it is loaded or dropped as an overrun.
    assign byte_done = (state == ST_STOP) && (cnt == BIT_LAST) && sample;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rdata    <= '0;
            rx_valid <= 1'b0;
            ferr     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            ferr    <= 1'b0;
            overrun <= 1'b0;

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (!rxd_s) begin
                        state <= ST_START;
                    end
                end

                ST_START: begin
                    if (cnt == START_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // A high line at mid start bit was only a glitch.
                        state   <= sample ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        // Enter at the MSB and shift right: the first bit
                        // received ends up in bit 0.
                        shift <= {sample, shift[UART_DATA_BITS-1:1]};
                        if (bit_idx == LAST_BIT) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        // Returning to IDLE at mid stop bit leaves half a
                        // bit of slack for a fast transmitter.
                        if (sample) begin
                            state <= ST_IDLE;
                        end else begin
                            ferr  <= 1'b1;
                            state <= ST_BREAK;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_BREAK: begin
                    // Hold off until the line recovers so a stuck-low line
                    // yields one framing error rather than a stream of 0x00.
                    cnt <= '0;
                    if (rxd_s) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase

            // One-entry output register. A byte arriving in the same cycle
            // the consumer takes the old one replaces it seamlessly.
            if (byte_done) begin
                if (!rx_valid || rx_ready) begin
                    rdata    <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx with H=4
module tb_uart_rx;
    import uart_pkg::*;

    localparam int H = 4;
    localparam int BITC = 2 * H;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int VL = 1;
`else
    localparam int VL = 0;
`endif
    // Drive of the start edge at cycle P: rxd_s low after P+2, IDLE sees it
    // at edge T=P+3, stop sample at T+19H, result visible after that edge.
    localparam int FRAME_LAT = 3 + 19 * H + VL;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       rxd;
    logic [7:0] rdata;
    logic       rx_valid;
    logic       rx_ready;
    logic       ferr;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int valid_cnt = 0;
    int valid_rise_cyc = -1;
    int ferr_cnt = 0;
    int ferr_cyc = -1;
    int ovr_cnt = 0;
    int ovr_cyc = -1;
    logic prev_valid = 1'b0;

    uart_rx #(
        .CLK_PER_HALF_BIT (H)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .rxd      (rxd),
        .rdata    (rdata),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .ferr     (ferr),
        .overrun  (overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    always @(negedge clock) begin
        if (rx_valid) valid_cnt = valid_cnt + 1;
        if (rx_valid && !prev_valid) valid_rise_cyc = cyc;
        prev_valid = rx_valid;
        if (ferr) begin
            ferr_cnt = ferr_cnt + 1;
            ferr_cyc = cyc;
        end
        if (overrun) begin
            ovr_cnt = ovr_cnt + 1;
            ovr_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        tick(BITC);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(BITC);
        end
        rxd = stop;
        tick(BITC);
        rxd = 1'b1;
    endtask

    task automatic test_reset;
        checks++;
        if (rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 00", rdata);
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rx_valid: got %b expected 0", rx_valid);
        end
        checks++;
        if (ferr !== 1'b0) begin
            errors++;
            $display("FAIL reset_ferr: got %b expected 0", ferr);
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_overrun: got %b expected 0", overrun);
        end
        checks++;
        if (dut.state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected %0d", dut.state, ST_IDLE);
        end
    endtask

    task automatic test_single_frame;
        int p, v0, f0, o0;
        rx_ready = 1'b1;
        v0 = valid_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        p = cyc;
        send_frame(8'h55, 1'b1);
        tick(BITC + 4);
        checks++;
        if (rdata !== 8'h55) begin
            errors++;
            $display("FAIL single_rdata: got %h expected 55", rdata);
        end
        checks++;
        if (valid_cnt - v0 != 1) begin
            errors++;
            $display("FAIL single_valid_width: got %0d expected 1", valid_cnt - v0);
        end
        checks++;
        if (valid_rise_cyc - p != FRAME_LAT) begin
            errors++;
            $display("FAIL single_valid_latency: got %0d expected %0d", valid_rise_cyc - p, FRAME_LAT);
        end
        checks++;
        if (ferr_cnt != f0) begin
            errors++;
            $display("FAIL single_no_ferr: got %0d expected %0d", ferr_cnt, f0);
        end
        checks++;
        if (ovr_cnt != o0) begin
            errors++;
            $display("FAIL single_no_overrun: got %0d expected %0d", ovr_cnt, o0);
        end
    endtask

    task automatic test_glitch;
        int v0, f0;
        v0 = valid_cnt; f0 = ferr_cnt;
        rxd = 1'b0;
        tick(2);
        rxd = 1'b1;
        tick(6);
        checks++;
        if (dut.state !== ST_IDLE) begin
            errors++;
            $display("FAIL glitch_state: got %0d expected %0d", dut.state, ST_IDLE);
        end
        tick(40);
        checks++;
        if (valid_cnt != v0) begin
            errors++;
            $display("FAIL glitch_no_valid: got %0d expected %0d", valid_cnt, v0);
        end
        checks++;
        if (ferr_cnt != f0) begin
            errors++;
            $display("FAIL glitch_no_ferr: got %0d expected %0d", ferr_cnt, f0);
        end
    endtask

    task automatic test_framing_error;
        int p, v0, f0;
        rx_ready = 1'b1;
        v0 = valid_cnt; f0 = ferr_cnt;
        p = cyc;
        send_frame(8'hA3, 1'b0);
        rxd = 1'b0;
        tick(40);
        rxd = 1'b1;
        tick(2 * BITC);
        checks++;
        if (ferr_cnt - f0 != 1) begin
            errors++;
            $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - f0);
        end
        checks++;
        if (ferr_cyc - p != FRAME_LAT) begin
            errors++;
            $display("FAIL ferr_latency: got %0d expected %0d", ferr_cyc - p, FRAME_LAT);
        end
        checks++;
        if (valid_cnt != v0) begin
            errors++;
            $display("FAIL ferr_no_valid: got %0d expected %0d", valid_cnt, v0);
        end
        v0 = valid_cnt;
        send_frame(8'h3C, 1'b1);
        tick(BITC + 4);
        checks++;
        if (rdata !== 8'h3C) begin
            errors++;
            $display("FAIL ferr_next_rdata: got %h expected 3c", rdata);
        end
        checks++;
        if (valid_cnt - v0 != 1) begin
            errors++;
            $display("FAIL ferr_next_valid: got %0d expected 1", valid_cnt - v0);
        end
        checks++;
        if (ferr_cnt - f0 != 1) begin
            errors++;
            $display("FAIL ferr_single_pulse: got %0d expected 1", ferr_cnt - f0);
        end
    endtask

    task automatic test_overrun;
        int p, o0;
        rx_ready = 1'b0;
        o0 = ovr_cnt;
        p = cyc;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(BITC + 4);
        checks++;
        if (rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovr_valid_held: got %b expected 1", rx_valid);
        end
        checks++;
        if (rdata !== 8'h11) begin
            errors++;
            $display("FAIL ovr_rdata_kept: got %h expected 11", rdata);
        end
        checks++;
        if (ovr_cnt - o0 != 1) begin
            errors++;
            $display("FAIL ovr_count: got %0d expected 1", ovr_cnt - o0);
        end
        checks++;
        if (ovr_cyc - p != 10 * BITC + FRAME_LAT) begin
            errors++;
            $display("FAIL ovr_latency: got %0d expected %0d", ovr_cyc - p, 10 * BITC + FRAME_LAT);
        end
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovr_consume_clears: got %b expected 0", rx_valid);
        end
    endtask

    task automatic test_back_to_back;
        int o0;
        rx_ready = 1'b0;
        o0 = ovr_cnt;
        fork
            begin
                send_frame(8'h11, 1'b1);
                send_frame(8'h22, 1'b1);
            end
            begin
                tick(10 * BITC + FRAME_LAT - 1);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
                checks++;
                if (rx_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_valid_stays: got %b expected 1", rx_valid);
                end
                checks++;
                if (rdata !== 8'h22) begin
                    errors++;
                    $display("FAIL b2b_rdata: got %h expected 22", rdata);
                end
            end
        join
        tick(BITC + 4);
        checks++;
        if (ovr_cnt != o0) begin
            errors++;
            $display("FAIL b2b_no_overrun: got %0d expected %0d", ovr_cnt, o0);
        end
        checks++;
        if (rdata !== 8'h22 || rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_hold: got %h/%b expected 22/1", rdata, rx_valid);
        end
    endtask

    task automatic test_reset_mid_frame;
        int v0, f0;
        rx_ready = 1'b0;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                tick(4 * BITC + 2);
                reset_n = 1'b0;
                tick(1);
                checks++;
                if (rdata !== 8'h00 || rx_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL midreset_outputs: got %h/%b expected 00/0", rdata, rx_valid);
                end
                checks++;
                if (ferr !== 1'b0 || overrun !== 1'b0) begin
                    errors++;
                    $display("FAIL midreset_pulses: got %b/%b expected 0/0", ferr, overrun);
                end
                checks++;
                if (dut.state !== ST_IDLE) begin
                    errors++;
                    $display("FAIL midreset_state: got %0d expected %0d", dut.state, ST_IDLE);
                end
                reset_n = 1'b1;
            end
        join
        v0 = valid_cnt; f0 = ferr_cnt;
        tick(2 * BITC);
        checks++;
        if (valid_cnt != v0 || ferr_cnt != f0) begin
            errors++;
            $display("FAIL midreset_quiet: got %0d/%0d expected %0d/%0d", valid_cnt, ferr_cnt, v0, f0);
        end
        rx_ready = 1'b1;
        send_frame(8'h81, 1'b1);
        tick(BITC + 4);
        checks++;
        if (rdata !== 8'h81) begin
            errors++;
            $display("FAIL midreset_next_rdata: got %h expected 81", rdata);
        end
        checks++;
        if (valid_cnt - v0 != 1) begin
            errors++;
            $display("FAIL midreset_next_valid: got %0d expected 1", valid_cnt - v0);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        rxd      = 1'b1;
        rx_ready = 1'b0;
        tick(3);
        test_reset;
        reset_n = 1'b1;
        tick(5);
        test_single_frame;
        test_glitch;
        test_framing_error;
        test_overrun;
        test_back_to_back;
        test_reset_mid_frame;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver, 8N1, LSB first, the receive-side counterpart of the design's UART transmitter, using the same bit-period parameterisation. It synchronises the asynchronous `rxd` pin and samples each bit at mid-period. Each received byte is held in a one-entry output register behind a valid/ready handshake for the core-side consumer. Framing errors and overruns are flagged as single-cycle pulses.

## Interface
- `CLK_PER_HALF_BIT`, default 30: clock cycles per half bit (H); one bit = 2H cycles; must be ≥ 2.
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `rxd`  in  1  serial line, asynchronous, idle high.
- `rdata`  out  8  received byte; valid while `rx_valid`.
- `rx_valid`  out  1  `rdata` holds an unconsumed byte.
- `rx_ready`  in  1  consumer accepts `rdata` when `rx_valid & rx_ready`.
- `ferr`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: byte completed while output register full and not being consumed.

## Operation
- `rxd` passes through a 2-flop synchroniser, giving `rxd_s`. The synchroniser flops reset to 1.
- States: IDLE, START, DATA, STOP, BREAK.
- **IDLE**
  - On `rxd_s==0`: go to START, clear counter.
- **START**
  - Counter runs 0..H-1. At H-1, sample `rxd_s`.
  - Sample 0: go to DATA, clear counter and bit index.
  - Sample 1: glitch; return to IDLE. No flag.
- **DATA**
  - Counter runs 0..2H-1. At 2H-1, shift the sample into the shift register MSB and shift right. This gives LSB-first assembly.
  - Bit index 0..7 (3-bit). After index 7 is sampled, go to STOP with counter cleared.
- **STOP**
  - At counter 2H-1, sample `rxd_s`.
  - Sample 1: byte complete; go to IDLE.
  - Sample 0: pulse `ferr`, discard the byte, go to BREAK.
- **BREAK**
  - Wait for `rxd_s==1`, then go to IDLE. Prevents a held-low line from producing repeated bytes.
- **Byte-complete rules**
  - `!rx_valid`: load `rdata`, set `rx_valid`.
  - `rx_valid & rx_ready` in the same cycle: load the new byte, `rx_valid` stays 1, no overrun.
  - `rx_valid & !rx_ready`: new byte dropped, `rdata` unchanged, pulse `overrun`.
- **Handshake**
  - `rx_valid & rx_ready` with no byte completing: clear `rx_valid` the next cycle.
  - `rdata` holds its value until the next load.
- Counter width: `$clog2(2*CLK_PER_HALF_BIT)`; it never wraps past 2H-1.

## Timing
- Reset values: `rdata`=0, `rx_valid`=0, `ferr`=0, `overrun`=0, state IDLE, counter 0.
- Reset asserted mid-frame:
  - Aborts immediately; all state returns to reset values.
  - After release, the receiver waits in IDLE for the next falling edge of `rxd_s`.
  - A partially received frame already in progress at release is resampled from its next low level and may produce `ferr`. This is accepted behaviour.
- `rxd_s` lags the `rxd` pin by 2 cycles.
- Let cycle T be the first cycle IDLE sees `rxd_s==0`:
  - Start-bit sample at T+H.
  - Data bit k (k=0..7) sampled at T+H+2H(k+1).
  - Stop sample at T+19H.
  - `rx_valid`/`ferr`/`overrun` visible at T+19H+1.
- Receiver is back in IDLE 1 cycle after the stop sample, half a bit early. This tolerates up to ~±4% baud mismatch.
- Back-to-back frames with no idle gap are received without loss.

## Configuration
- `UART_RX_MAJORITY_VOTE_EN`
  - Defined: each sample point (start, data, stop) uses a 2-of-3 majority of `rxd_s` taken at counter values target-1, target, target+1. The decision is made at target+1 and all sampling latencies shift by +1 cycle.
  - Requires H ≥ 2.
  - Undefined: single sample at the target counter value, timing exactly as above.

## Structure
- Package `uart_pkg`:
  - state enum `uart_rx_state_t`.
  - `UART_DATA_BITS`=8.
  - a `clk_per_bit(h)` helper function shared with the transmitter.
- Sub-module `uart_sync2`: 2-flop synchroniser with a parameterised reset value. Reusable for other async inputs.

## Test plan
All scenarios run with H=4.
- Frame 0x55, 1 idle bit, `rx_ready`=1 → `rdata`=0x55, `rx_valid` high exactly 1 cycle, at T+19H+1=T+77.
- Low glitch of 2 cycles on idle `rxd` → no `rx_valid`, no `ferr`; state back to IDLE by T+5.
- Frame 0xA3 with stop bit forced 0, line held low 40 cycles, then high → single `ferr` pulse, no `rx_valid`, next frame 0x3C is received correctly.
- Frames 0x11 then 0x22 back-to-back with `rx_ready`=0 → `rdata` stays 0x11, one `overrun` pulse. Then `rx_ready`=1 → `rx_valid` clears the following cycle.
- `rx_ready` asserted in the exact cycle the second byte completes → `rdata`=0x22, `rx_valid` stays 1, no `overrun`.
- `reset_n` pulsed low during data bit 3 of frame 0xFF → outputs at reset values; a following clean frame 0x81 is received correctly.
